// File: rtl/page_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// page_cmd_arbiter
//
// Shares a single NAND-channel page-command port between NREQ command
// schedulers. Arbitration is round-robin at sequence granularity: a granted
// requester keeps the port until its last=1 beat is accepted, so multi-plane
// command sequences are never interleaved. A stalled owner that stops
// presenting beats for LOCK_TO cycles is forcibly released (LOCK_TO=0
// disables this). The downstream side is a single registered output slot.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   i_req_valid        per-requester beat valid
//   o_req_ready        per-requester beat ready (only the owner, only when slot free)
//   i_req_cmd/last/id/addr/param  per-requester beat fields, requester k at slice k
//   i_page_cmd_ready   downstream ready
//   o_page_cmd_valid   downstream valid (registered)
//   o_page_cmd/_last/_id, o_page_addr, o_page_cmd_param  forwarded beat fields
//   o_grant_idx        current or most recent owner
//   o_busy             high while a requester owns the port
//   o_lock_err         one-cycle pulse on a timeout-forced release
// ----------------------------------------------------------------------------
module page_cmd_arbiter #(
    parameter int NREQ    = 3,
    parameter int LOCK_TO = 1024,
    parameter int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [16*NREQ-1:0]   i_req_cmd,
    input  logic [NREQ-1:0]      i_req_last,
    input  logic [16*NREQ-1:0]   i_req_id,
    input  logic [48*NREQ-1:0]   i_req_addr,
    input  logic [32*NREQ-1:0]   i_req_param,
    input  logic                 i_page_cmd_ready,
    output logic                 o_page_cmd_valid,
    output logic [15:0]          o_page_cmd,
    output logic                 o_page_cmd_last,
    output logic [15:0]          o_page_cmd_id,
    output logic [47:0]          o_page_addr,
    output logic [31:0]          o_page_cmd_param,
    output logic [GW-1:0]        o_grant_idx,
    output logic                 o_busy,
    output logic                 o_lock_err
);

    localparam int TW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

    typedef enum logic {StIdle, StLock} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_rr_ptr;
    logic [TW-1:0]   r_timer;
    logic            r_lock_err;
    logic            r_valid;
    logic [15:0]     r_cmd;
    logic            r_last;
    logic [15:0]     r_id;
    logic [47:0]     r_addr;
    logic [31:0]     r_param;

    logic            w_slot_free;
    logic            w_owner_valid;
    logic            w_accept;
    logic            w_acc_last;
    logic            w_timeout;
    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [GW-1:0]   w_idx;

    // Slot can take a new beat if empty or draining this very cycle.
    assign w_slot_free   = ~r_valid | i_page_cmd_ready;
    assign w_owner_valid = i_req_valid[r_grant];
    assign w_accept      = (r_state == StLock) & w_slot_free & w_owner_valid;
    assign w_acc_last    = i_req_last[r_grant];

    // Only an absent owner counts toward the timeout; a backpressured owner does not.
    assign w_timeout = (LOCK_TO != 0) & (r_state == StLock) & ~w_owner_valid &
                       (r_timer == TW'(LOCK_TO - 1));

    // Round-robin scan starting one past the previous owner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = GW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_next = StLock;
                end
            end
            StLock: begin
                if ((w_accept && w_acc_last) || w_timeout) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_req_ready = '0;
        o_busy      = (r_state == StLock);
        if (r_state == StLock && w_slot_free) begin
            o_req_ready[r_grant] = 1'b1;
        end
    end

    // Grant bookkeeping, timeout timer and output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_rr_ptr   <= GW'(NREQ - 1);
            r_timer    <= '0;
            r_lock_err <= 1'b0;
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_last     <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_param    <= '0;
        end else begin
            r_lock_err <= w_timeout;

            if (w_accept) begin
                r_valid <= 1'b1;
                r_cmd   <= i_req_cmd[16*r_grant +: 16];
                r_last  <= w_acc_last;
                r_id    <= i_req_id[16*r_grant +: 16];
                r_addr  <= i_req_addr[48*r_grant +: 48];
                r_param <= i_req_param[32*r_grant +: 32];
            end else if (i_page_cmd_ready) begin
                r_valid <= 1'b0;
            end

            if (r_state == StIdle) begin
                r_timer <= '0;
                if (w_found) begin
                    r_grant <= w_winner;
                end
            end else if (w_accept) begin
                r_timer <= '0;
                if (w_acc_last) begin
                    r_rr_ptr <= r_grant;
                end
            end else if (w_timeout) begin
                r_timer  <= '0;
                r_rr_ptr <= r_grant;
            end else if (!w_owner_valid && LOCK_TO != 0) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    assign o_page_cmd_valid = r_valid;
    assign o_page_cmd       = r_cmd;
    assign o_page_cmd_last  = r_last;
    assign o_page_cmd_id    = r_id;
    assign o_page_addr      = r_addr;
    assign o_page_cmd_param = r_param;
    assign o_grant_idx      = r_grant;
    assign o_lock_err       = r_lock_err;

endmodule
